ysyx_23060077_riscv_axi_lite_sram: RTL and testbench
====================================================

// Module: ysyx_23060077_riscv_axi_lite_sram
// PURPOSE
//   Parametrised AXI4-Lite slave memory for NPC simulation/FPGA, holding an internal DEPTH-word array (no DPI).
//   Independent read and write channels, any AW/W arrival order, byte strobes.
//   Programmable response latency per direction.
//   SLVERR on out-of-range addresses. Sits behind the core's AXI arbiter as IFU/LSU backing store.
// PARAMETERS
//   ADDR_W     32            address width
//   DATA_W     32            data width; power of 2, >= 8; STRB_W = DATA_W/8
//   PORT_W     3             AxPROT width; accepted, ignored
//   DEPTH      1024          memory size in DATA_W words
//   BASE_ADDR  32'h8000_0000 byte address of word 0
//   RD_LAT     1             extra read wait cycles, 0..15
//   WR_LAT     1             extra write wait cycles, 0..15
// PORTS
//   aclk            in   1        clock; everything on posedge
//   areset          in   1        synchronous reset, active-high
//   axi_aw_ready_o  out  1        write address ready
//   axi_aw_valid_i  in   1        write address valid
//   axi_aw_port_i   in   PORT_W   write prot, ignored
//   axi_aw_addr_i   in   ADDR_W   write byte address
//   axi_w_ready_o   out  1        write data ready
//   axi_w_valid_i   in   1        write data valid
//   axi_w_strb_i    in   STRB_W   byte enables
//   axi_w_data_i    in   DATA_W   write data
//   axi_b_resp_o    out  2        write resp: 2'b00 OKAY, 2'b10 SLVERR
//   axi_b_valid_o   out  1        write resp valid
//   axi_b_ready_i   in   1        write resp ready
//   axi_ar_ready_o  out  1        read address ready
//   axi_ar_valid_i  in   1        read address valid
//   axi_ar_port_i   in   PORT_W   read prot, ignored
//   axi_ar_addr_i   in   ADDR_W   read byte address
//   axi_r_ready_i   in   1        read data ready
//   axi_r_valid_o   out  1        read data valid
//   axi_r_resp_o    out  2        read resp, encoding as B
//   axi_r_data_o    out  DATA_W   read data
// BEHAVIOUR
//   Reset: all ready/valid 0, resp 2'b00, r_data 0, FSMs IDLE, capture flags clear; array contents not reset.
//   Reset is synchronous with priority; in-flight transactions are dropped. No array write occurs on a reset cycle.
//   Decode: idx = (addr-BASE_ADDR) >> log2(STRB_W). Low addr bits ignored.
//     Error if addr < BASE_ADDR or idx >= DEPTH.
//   Handshake = valid & ready on a posedge. Ready is a registered output and is independent of valid.
//   Write FSM: W_IDLE -> W_LAT -> W_RESP -> W_IDLE.
//     W_IDLE: aw_ready = !aw_got, w_ready = !w_got. Each handshake latches addr or data+strb and sets its flag.
//       Same-cycle AW+W is allowed. Once both flags are set -> W_LAT, cnt = WR_LAT, both readies 0.
//     W_LAT: cnt decrements each cycle. At cnt==0 is the commit cycle:
//       if OK, mem[idx] byte i <= data byte i where strb[i]; if error, no write.
//       -> W_RESP, b_valid=1, b_resp set.
//     W_RESP: hold b_valid/b_resp stable until b_ready. Then -> W_IDLE, flags clear, readies 1 next cycle.
//     Latency: b_valid rises WR_LAT+1 cycles after the later of AW/W handshake. strb==0 gives OKAY, array unchanged.
//   Read FSM: R_IDLE -> R_LAT -> R_DATA -> R_IDLE.
//     R_IDLE: ar_ready=1. Handshake latches addr -> R_LAT, cnt = RD_LAT, ar_ready 0.
//     R_LAT: at cnt==0 sample mem[idx] (data 0 + SLVERR if error). -> R_DATA, r_valid=1.
//     R_DATA: r_valid/r_data/r_resp held stable until r_ready, then -> R_IDLE.
//     Latency: r_valid rises RD_LAT+1 cycles after AR handshake.
//   Read/write collision: read sample and write commit on the same word in the same cycle -> read returns pre-write data.
//   One outstanding transaction per direction; no IDs, no bursts.
// TESTING
//   1. Write 0xDEADBEEF, strb 0xF, to BASE_ADDR; read BASE_ADDR -> B OKAY, R data 0xDEADBEEF, OKAY.
//   2. Then write 0x00001234, strb 0x3, to BASE_ADDR; read -> 0xDEAD1234.
//   3. W valid 3 cycles before AW (BASE+8) -> exactly one B, WR_LAT+1 cycles after AW handshake; readback matches.
//   4. AW/AR at BASE_ADDR+4*DEPTH and BASE_ADDR-4 -> B SLVERR; R SLVERR, data 0; words 0 and DEPTH-1 unchanged.
//   5. RD_LAT=3, r_ready low 5 cycles -> r_valid at AR+4 cycles; data/resp stable until r_ready.
//   6. areset pulsed in W_LAT, then read the target word -> old value, all valids 0 the cycle after reset.

Source files
------------

// File: rtl/ysyx_23060077_riscv_axi_lite_sram.sv
// AXI4-Lite slave memory with an internal word array, independent read/write
// channels and programmable per-direction response latency.
module ysyx_23060077_riscv_axi_lite_sram #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                PORT_W    = 3,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int                RD_LAT    = 1,
    parameter int                WR_LAT    = 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    output logic                   axi_aw_ready_o,
    input  logic                   axi_aw_valid_i,
    input  logic [PORT_W-1:0]      axi_aw_port_i,
    input  logic [ADDR_W-1:0]      axi_aw_addr_i,
    output logic                   axi_w_ready_o,
    input  logic                   axi_w_valid_i,
    input  logic [DATA_W/8-1:0]    axi_w_strb_i,
    input  logic [DATA_W-1:0]      axi_w_data_i,
    output logic [1:0]             axi_b_resp_o,
    output logic                   axi_b_valid_o,
    input  logic                   axi_b_ready_i,
    output logic                   axi_ar_ready_o,
    input  logic                   axi_ar_valid_i,
    input  logic [PORT_W-1:0]      axi_ar_port_i,
    input  logic [ADDR_W-1:0]      axi_ar_addr_i,
    input  logic                   axi_r_ready_i,
    output logic                   axi_r_valid_o,
    output logic [1:0]             axi_r_resp_o,
    output logic [DATA_W-1:0]      axi_r_data_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE, W_LAT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t          w_state, w_state_n;
    logic [3:0]        w_cnt, w_cnt_n;
    logic              aw_got, aw_got_n, w_got, w_got_n;
    logic              aw_ready_n, w_ready_n, b_valid_n;
    logic [1:0]        b_resp_n;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              aw_hs, w_hs, wr_commit, wr_err;
    logic [ADDR_W-1:0] wr_word;
    logic [IDX_W-1:0]  wr_idx;

    r_state_t          r_state, r_state_n;
    logic [3:0]        r_cnt, r_cnt_n;
    logic              ar_ready_n, r_valid_n;
    logic [ADDR_W-1:0] ar_addr_q;
    logic              ar_hs, rd_sample, rd_err;
    logic [ADDR_W-1:0] rd_word;
    logic [IDX_W-1:0]  rd_idx;

    logic              unused_prot;
    assign unused_prot = ^{axi_aw_port_i, axi_ar_port_i};

    // Word decode: low address bits are dropped, anything outside the array errors
    assign aw_hs     = axi_aw_valid_i & axi_aw_ready_o;
    assign w_hs      = axi_w_valid_i & axi_w_ready_o;
    assign wr_word   = (aw_addr_q - BASE_ADDR) >> SHIFT;
    assign wr_err    = (aw_addr_q < BASE_ADDR) || (wr_word >= ADDR_W'(DEPTH));
    assign wr_idx    = wr_word[IDX_W-1:0];
    assign wr_commit = (w_state == W_LAT) && (w_cnt == 4'd0);

    assign ar_hs     = axi_ar_valid_i & axi_ar_ready_o;
    assign rd_word   = (ar_addr_q - BASE_ADDR) >> SHIFT;
    assign rd_err    = (ar_addr_q < BASE_ADDR) || (rd_word >= ADDR_W'(DEPTH));
    assign rd_idx    = rd_word[IDX_W-1:0];
    assign rd_sample = (r_state == R_LAT) && (r_cnt == 4'd0);

    always_comb begin
        w_state_n  = w_state;
        w_cnt_n    = w_cnt;
        aw_got_n   = aw_got;
        w_got_n    = w_got;
        aw_ready_n = 1'b0;
        w_ready_n  = 1'b0;
        b_valid_n  = axi_b_valid_o;
        b_resp_n   = axi_b_resp_o;
        case (w_state)
            W_IDLE: begin
                aw_got_n = aw_got | aw_hs;
                w_got_n  = w_got | w_hs;
                if (aw_got_n && w_got_n) begin
                    w_state_n = W_LAT;
                    w_cnt_n   = 4'(WR_LAT);
                end else begin
                    aw_ready_n = !aw_got_n;
                    w_ready_n  = !w_got_n;
                end
            end
            W_LAT: begin
                if (w_cnt == 4'd0) begin
                    w_state_n = W_RESP;
                    b_valid_n = 1'b1;
                    b_resp_n  = wr_err ? 2'b10 : 2'b00;
                end else begin
                    w_cnt_n = w_cnt - 4'd1;
                end
            end
            W_RESP: begin
                if (axi_b_ready_i) begin
                    w_state_n  = W_IDLE;
                    b_valid_n  = 1'b0;
                    aw_got_n   = 1'b0;
                    w_got_n    = 1'b0;
                    aw_ready_n = 1'b1;
                    w_ready_n  = 1'b1;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state        <= W_IDLE;
            w_cnt          <= 4'd0;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
            axi_aw_ready_o <= 1'b0;
            axi_w_ready_o  <= 1'b0;
            axi_b_valid_o  <= 1'b0;
            axi_b_resp_o   <= 2'b00;
        end else begin
            w_state        <= w_state_n;
            w_cnt          <= w_cnt_n;
            aw_got         <= aw_got_n;
            w_got          <= w_got_n;
            axi_aw_ready_o <= aw_ready_n;
            axi_w_ready_o  <= w_ready_n;
            axi_b_valid_o  <= b_valid_n;
            axi_b_resp_o   <= b_resp_n;
        end
    end

    always_ff @(posedge aclk) begin
        if (aw_hs) aw_addr_q <= axi_aw_addr_i;
        if (w_hs) begin
            w_data_q <= axi_w_data_i;
            w_strb_q <= axi_w_strb_i;
        end
        if (ar_hs) ar_addr_q <= axi_ar_addr_i;
    end

    // A reset cycle must never disturb the array, even on the commit cycle
    always_ff @(posedge aclk) begin
        if (!areset && wr_commit && !wr_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb_q[i]) mem[wr_idx][i*8 +: 8] <= w_data_q[i*8 +: 8];
            end
        end
    end

    always_comb begin
        r_state_n  = r_state;
        r_cnt_n    = r_cnt;
        ar_ready_n = 1'b0;
        r_valid_n  = axi_r_valid_o;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_n = R_LAT;
                    r_cnt_n   = 4'(RD_LAT);
                end else begin
                    ar_ready_n = 1'b1;
                end
            end
            R_LAT: begin
                if (r_cnt == 4'd0) begin
                    r_state_n = R_DATA;
                    r_valid_n = 1'b1;
                end else begin
                    r_cnt_n = r_cnt - 4'd1;
                end
            end
            R_DATA: begin
                if (axi_r_ready_i) begin
                    r_state_n  = R_IDLE;
                    r_valid_n  = 1'b0;
                    ar_ready_n = 1'b1;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // Sampling with a non-blocking read returns pre-write data on a same-cycle commit
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state        <= R_IDLE;
            r_cnt          <= 4'd0;
            axi_ar_ready_o <= 1'b0;
            axi_r_valid_o  <= 1'b0;
            axi_r_resp_o   <= 2'b00;
            axi_r_data_o   <= '0;
        end else begin
            r_state        <= r_state_n;
            r_cnt          <= r_cnt_n;
            axi_ar_ready_o <= ar_ready_n;
            axi_r_valid_o  <= r_valid_n;
            if (rd_sample) begin
                axi_r_data_o <= rd_err ? '0 : mem[rd_idx];
                axi_r_resp_o <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_riscv_axi_lite_sram.sv
// Self-checking bench for the AXI4-Lite SRAM: directed vector table, corner-case
// sequences and randomized traffic against a byte-level reference memory.
module tb_ysyx_23060077_riscv_axi_lite_sram;

    localparam int          DEPTH  = 64;
    localparam int          RD_LAT = 3;
    localparam int          WR_LAT = 1;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic        aclk, areset;
    logic        aw_ready, aw_valid, w_ready, w_valid, b_valid, b_ready;
    logic        ar_ready, ar_valid, r_ready, r_valid;
    logic [2:0]  aw_port, ar_port;
    logic [31:0] aw_addr, ar_addr, w_data, r_data;
    logic [3:0]  w_strb;
    logic [1:0]  b_resp, r_resp;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_delay;
        int          w_delay;
        logic [1:0]  exp_b;
        logic [1:0]  exp_r;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    ysyx_23060077_riscv_axi_lite_sram #(
        .ADDR_W(32), .DATA_W(32), .PORT_W(3), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .aclk(aclk), .areset(areset),
        .axi_aw_ready_o(aw_ready), .axi_aw_valid_i(aw_valid), .axi_aw_port_i(aw_port),
        .axi_aw_addr_i(aw_addr), .axi_w_ready_o(w_ready), .axi_w_valid_i(w_valid),
        .axi_w_strb_i(w_strb), .axi_w_data_i(w_data), .axi_b_resp_o(b_resp),
        .axi_b_valid_o(b_valid), .axi_b_ready_i(b_ready), .axi_ar_ready_o(ar_ready),
        .axi_ar_valid_i(ar_valid), .axi_ar_port_i(ar_port), .axi_ar_addr_i(ar_addr),
        .axi_r_ready_i(r_ready), .axi_r_valid_o(r_valid), .axi_r_resp_o(r_resp),
        .axi_r_data_o(r_data)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                   input int awd, input int wd, input logic [1:0] eb,
                                   input logic [1:0] er, input logic [31:0] ed);
        vec_t v;
        v.addr = a; v.wdata = d; v.strb = s; v.aw_delay = awd; v.w_delay = wd;
        v.exp_b = eb; v.exp_r = er; v.exp_rdata = ed;
        return v;
    endfunction

    // Reference model: byte offset from BASE must land inside the DEPTH*4 byte window
    function automatic bit inRange(input logic [31:0] a);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        return (off >= 0) && (off < 4 * DEPTH);
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (inRange(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[wordOf(a)][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int w_delay,
                           output logic [1:0] resp, output int lat);
        bit aw_done, w_done, aw_fire, w_fire;
        int k, n;
        aw_done = 0; w_done = 0; k = 0; n = 0; resp = 2'b11; lat = -1;
        aw_addr = addr; w_data = data; w_strb = strb; aw_port = 3'($urandom);
        while (!(aw_done && w_done) && k < 64) begin
            @(negedge aclk);
            aw_valid = !aw_done && (k >= aw_delay);
            w_valid  = !w_done && (k >= w_delay);
            aw_fire  = aw_valid && aw_ready;
            w_fire   = w_valid && w_ready;
            @(posedge aclk);
            aw_done = aw_done | aw_fire;
            w_done  = w_done | w_fire;
            k++;
        end
        if (!(aw_done && w_done)) begin
            @(negedge aclk);
            aw_valid = 0; w_valid = 0;
            checkOutput("aw_w_handshake_timeout", 0, 1);
            return;
        end
        while (n < 40) begin
            @(negedge aclk);
            aw_valid = 0; w_valid = 0;
            if (b_valid) break;
            @(posedge aclk);
            n++;
        end
        if (!b_valid) begin
            checkOutput("b_valid_timeout", 0, 1);
            return;
        end
        lat = n; resp = b_resp;
        b_ready = 1;
        @(posedge aclk);
        @(negedge aclk);
        b_ready = 0;
        checkOutput("b_single", b_valid, 0);
    endtask

    task automatic doRead(input logic [31:0] addr, input int ar_delay, input int hold,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
        bit done, fire;
        int k, n;
        done = 0; k = 0; n = 0; data = 'x; resp = 2'b11; lat = -1;
        ar_addr = addr; ar_port = 3'($urandom);
        while (!done && k < 64) begin
            @(negedge aclk);
            ar_valid = (k >= ar_delay);
            fire = ar_valid && ar_ready;
            @(posedge aclk);
            done = fire;
            k++;
        end
        if (!done) begin
            @(negedge aclk);
            ar_valid = 0;
            checkOutput("ar_handshake_timeout", 0, 1);
            return;
        end
        while (n < 40) begin
            @(negedge aclk);
            ar_valid = 0;
            if (r_valid) break;
            @(posedge aclk);
            n++;
        end
        if (!r_valid) begin
            checkOutput("r_valid_timeout", 0, 1);
            return;
        end
        lat = n; data = r_data; resp = r_resp;
        for (int h = 0; h < hold; h++) begin
            @(posedge aclk);
            @(negedge aclk);
            checkOutput("r_hold_valid", r_valid, 1);
            checkOutput("r_hold_data", r_data, data);
            checkOutput("r_hold_resp", r_resp, resp);
        end
        r_ready = 1;
        @(posedge aclk);
        @(negedge aclk);
        r_ready = 0;
        checkOutput("r_single", r_valid, 0);
    endtask

    task automatic applyStimulus(input int i, input vec_t v);
        logic [1:0]  br, rr;
        logic [31:0] rd;
        int          wl, rl;
        doWrite(v.addr, v.wdata, v.strb, v.aw_delay, v.w_delay, br, wl);
        modelWrite(v.addr, v.wdata, v.strb);
        checkOutput($sformatf("vec%0d_bresp", i), br, v.exp_b);
        checkOutput($sformatf("vec%0d_wlat", i), wl, WR_LAT + 1);
        doRead(v.addr, 0, 0, rd, rr, rl);
        checkOutput($sformatf("vec%0d_rresp", i), rr, v.exp_r);
        checkOutput($sformatf("vec%0d_rdata", i), rd, v.exp_rdata);
        checkOutput($sformatf("vec%0d_rlat", i), rl, RD_LAT + 1);
    endtask

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd, old, a, d;
        logic [3:0]  s;
        int          wl, rl;

        areset = 1; aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
        aw_port = 0; ar_port = 0; aw_addr = 0; ar_addr = 0; w_data = 0; w_strb = 0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst_aw_ready", aw_ready, 0);
        checkOutput("rst_w_ready", w_ready, 0);
        checkOutput("rst_ar_ready", ar_ready, 0);
        checkOutput("rst_b_valid", b_valid, 0);
        checkOutput("rst_r_valid", r_valid, 0);
        checkOutput("rst_b_resp", b_resp, 0);
        checkOutput("rst_r_resp", r_resp, 0);
        checkOutput("rst_r_data", r_data, 0);
        areset = 0;
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("post_rst_aw_ready", aw_ready, 1);
        checkOutput("post_rst_w_ready", w_ready, 1);
        checkOutput("post_rst_ar_ready", ar_ready, 1);

        // Expected read data is derived by hand from the cumulative effect of earlier rows
        vecs.push_back(mkVec(BASE,             32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 2'b00, 32'hDEADBEEF));
        vecs.push_back(mkVec(BASE,             32'h00001234, 4'h3, 0, 0, 2'b00, 2'b00, 32'hDEAD1234));
        vecs.push_back(mkVec(BASE + 32'h8,     32'hCAFEF00D, 4'hF, 3, 0, 2'b00, 2'b00, 32'hCAFEF00D));
        vecs.push_back(mkVec(BASE + 32'h4,     32'h01234567, 4'hF, 1, 2, 2'b00, 2'b00, 32'h01234567));
        vecs.push_back(mkVec(BASE + 32'hFF,    32'h5A5A5A5A, 4'hF, 0, 0, 2'b00, 2'b00, 32'h5A5A5A5A));
        vecs.push_back(mkVec(BASE + 32'hFC,    32'hFFFFFFFF, 4'h0, 0, 0, 2'b00, 2'b00, 32'h5A5A5A5A));
        vecs.push_back(mkVec(BASE + 32'hFC,    32'h00C30000, 4'h4, 0, 0, 2'b00, 2'b00, 32'h5AC35A5A));
        vecs.push_back(mkVec(BASE + 32'h2,     32'h00AB0000, 4'h4, 2, 0, 2'b00, 2'b00, 32'hDEAB1234));
        vecs.push_back(mkVec(BASE + 32'h100,   32'h11111111, 4'hF, 0, 0, 2'b10, 2'b10, 32'h0));
        vecs.push_back(mkVec(BASE - 32'h4,     32'h22222222, 4'hF, 0, 1, 2'b10, 2'b10, 32'h0));
        vecs.push_back(mkVec(32'hFFFF_FFFC,    32'h33333333, 4'hF, 2, 0, 2'b10, 2'b10, 32'h0));
        foreach (vecs[i]) applyStimulus(i, vecs[i]);

        doRead(BASE, 0, 0, rd, rr, rl);
        checkOutput("word0_unchanged", rd, 32'hDEAB1234);
        doRead(BASE + 32'hFC, 0, 0, rd, rr, rl);
        checkOutput("wordlast_unchanged", rd, 32'h5AC35A5A);

        doRead(BASE + 32'h8, 0, 5, rd, rr, rl);
        checkOutput("hold_rlat", rl, RD_LAT + 1);
        checkOutput("hold_rdata", rd, 32'hCAFEF00D);
        checkOutput("hold_rresp", rr, 2'b00);

        // Reset while the write is waiting out its latency: the commit must be lost
        @(negedge aclk);
        checkOutput("pre_rst_aw_ready", aw_ready, 1);
        checkOutput("pre_rst_w_ready", w_ready, 1);
        aw_addr = BASE; w_data = 32'h99999999; w_strb = 4'hF; aw_valid = 1; w_valid = 1;
        @(posedge aclk);
        @(negedge aclk);
        aw_valid = 0; w_valid = 0; areset = 1;
        @(posedge aclk);
        @(negedge aclk);
        areset = 0;
        checkOutput("wlat_rst_b_valid", b_valid, 0);
        checkOutput("wlat_rst_r_valid", r_valid, 0);
        checkOutput("wlat_rst_aw_ready", aw_ready, 0);
        checkOutput("wlat_rst_ar_ready", ar_ready, 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge aclk);
            @(negedge aclk);
            checkOutput("wlat_rst_no_b", b_valid, 0);
        end
        doRead(BASE, 0, 0, rd, rr, rl);
        checkOutput("wlat_rst_old_data", rd, ref_mem[0]);

        doWrite(BASE + 32'h14, 32'h0BADF00D, 4'hF, 0, 0, br, wl);
        modelWrite(BASE + 32'h14, 32'h0BADF00D, 4'hF);
        old = ref_mem[5];
        fork
            doWrite(BASE + 32'h14, 32'h600DCAFE, 4'hF, 2, 2, br, wl);
            doRead(BASE + 32'h14, 0, 0, rd, rr, rl);
        join
        checkOutput("collide_pre_write_data", rd, old);
        checkOutput("collide_bresp", br, 2'b00);
        modelWrite(BASE + 32'h14, 32'h600DCAFE, 4'hF);
        doRead(BASE + 32'h14, 0, 0, rd, rr, rl);
        checkOutput("collide_new_data", rd, ref_mem[5]);

        for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            doWrite(BASE + 32'(4 * w), d, 4'hF, 0, 0, br, wl);
            modelWrite(BASE + 32'(4 * w), d, 4'hF);
            checkOutput("prefill_bresp", br, 2'b00);
        end

        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255))
                                                : BASE - 32'($urandom_range(1, 256));
            else
                a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom);
                doWrite(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), br, wl);
                checkOutput("rand_bresp", br, inRange(a) ? 2'b00 : 2'b10);
                checkOutput("rand_wlat", wl, WR_LAT + 1);
                modelWrite(a, d, s);
            end else begin
                doRead(a, $urandom_range(0, 3), $urandom_range(0, 2), rd, rr, rl);
                checkOutput("rand_rresp", rr, inRange(a) ? 2'b00 : 2'b10);
                checkOutput("rand_rdata", rd, inRange(a) ? ref_mem[wordOf(a)] : 32'h0);
                checkOutput("rand_rlat", rl, RD_LAT + 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
